// File: rtl/movement.sv
// ---------------------------------------------------------------------------
// movement -- three-floor elevator motion and door controller.
//
// Latches floor requests from the car panel and the hall panel, moves the car
// one floor per TRAVEL_CYCLES clocks, and opens the doors for DOOR_CYCLES
// clocks at every requested floor in travel order.
//
// Ports
//   CLK            in   rising-edge clock
//   RST            in   synchronous, active-high reset
//   interior_panel in   [2:0] car-panel requests, bit n = floor n
//   exterior_panel in   [2:0] hall-call requests, bit n = floor n
//   engine         out  [1:0] registered motor command: 00 stop, 01 up, 10 down
//   doors          out  [2:0] registered door command, one-hot on the current
//                              floor while open, 000 otherwise
// ---------------------------------------------------------------------------
module movement #(
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] interior_panel,
    input  logic [2:0] exterior_panel,
    output logic [1:0] engine,
    output logic [2:0] doors
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DOOR_LAST   = 8'(DOOR_CYCLES - 1);

    state_t     state, state_nx;
    dir_t       last_dir, last_dir_nx;
    logic [1:0] floor, floor_nx;
    logic [2:0] pending, pending_nx;
    logic [7:0] move_cnt, move_cnt_nx;
    logic [7:0] door_cnt, door_cnt_nx;
    logic [1:0] engine_nx;
    logic [2:0] doors_nx;

    logic       req_here, req_above, req_below;
    logic [1:0] floor_up, floor_down;

    function automatic logic [2:0] onehot(input logic [1:0] f);
        return 3'b001 << f;
    endfunction

    function automatic logic [2:0] above_mask(input logic [1:0] f);
        case (f)
            2'd0:    return 3'b110;
            2'd1:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] below_mask(input logic [1:0] f);
        case (f)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            default: return 3'b011;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            last_dir <= DIR_NONE;
            floor    <= '0;
            pending  <= '0;
            move_cnt <= '0;
            door_cnt <= '0;
            engine   <= '0;
            doors    <= '0;
        end else begin
            state    <= state_nx;
            last_dir <= last_dir_nx;
            floor    <= floor_nx;
            pending  <= pending_nx;
            move_cnt <= move_cnt_nx;
            door_cnt <= door_cnt_nx;
            engine   <= engine_nx;
            doors    <= doors_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        last_dir_nx = last_dir;
        floor_nx    = floor;
        move_cnt_nx = move_cnt;
        door_cnt_nx = door_cnt;

        // Decisions look only at the registered pending vector.
        req_here   = |(pending & onehot(floor));
        req_above  = |(pending & above_mask(floor));
        req_below  = |(pending & below_mask(floor));
        // Saturating neighbours keep the floor register inside 0..2 even
        // if a move state were somehow reached at a boundary.
        floor_up   = (floor == 2'd2) ? 2'd2 : floor + 2'd1;
        floor_down = (floor == 2'd0) ? 2'd0 : floor - 2'd1;

        case (state)
            IDLE: begin
                if (req_here) begin
                    state_nx    = DOOR_OPEN;
                    door_cnt_nx = '0;
                end else if (req_above && (!req_below || last_dir != DIR_DOWN)) begin
                    state_nx    = MOVE_UP;
                    move_cnt_nx = '0;
                    last_dir_nx = DIR_UP;
                end else if (req_below) begin
                    state_nx    = MOVE_DOWN;
                    move_cnt_nx = '0;
                    last_dir_nx = DIR_DOWN;
                end
            end

            MOVE_UP: begin
                if (move_cnt == TRAVEL_LAST) begin
                    move_cnt_nx = '0;
                    floor_nx    = floor_up;
                    if (|(pending & onehot(floor_up))) begin
                        state_nx    = DOOR_OPEN;
                        door_cnt_nx = '0;
                    end else if (!(|(pending & above_mask(floor_up)))) begin
                        state_nx = IDLE;
                    end
                end else begin
                    move_cnt_nx = move_cnt + 8'd1;
                end
            end

            MOVE_DOWN: begin
                if (move_cnt == TRAVEL_LAST) begin
                    move_cnt_nx = '0;
                    floor_nx    = floor_down;
                    if (|(pending & onehot(floor_down))) begin
                        state_nx    = DOOR_OPEN;
                        door_cnt_nx = '0;
                    end else if (!(|(pending & below_mask(floor_down)))) begin
                        state_nx = IDLE;
                    end
                end else begin
                    move_cnt_nx = move_cnt + 8'd1;
                end
            end

            DOOR_OPEN: begin
                if (door_cnt == DOOR_LAST) begin
                    state_nx    = IDLE;
                    door_cnt_nx = '0;
                end else begin
                    door_cnt_nx = door_cnt + 8'd1;
                end
            end

            default: state_nx = IDLE;
        endcase

        // The serviced floor's bit is masked on the entry edge, throughout the
        // open period and on the closing edge, so presses there are absorbed.
        pending_nx = pending | interior_panel | exterior_panel;
        if (state == DOOR_OPEN || state_nx == DOOR_OPEN) begin
            pending_nx = pending_nx & ~onehot(floor_nx);
        end

        case (state_nx)
            MOVE_UP:   engine_nx = 2'b01;
            MOVE_DOWN: engine_nx = 2'b10;
            default:   engine_nx = 2'b00;
        endcase
        doors_nx = (state_nx == DOOR_OPEN) ? onehot(floor_nx) : 3'b000;
    end

endmodule

// File: tb/tb_movement.sv
// ---------------------------------------------------------------------------
// tb_movement -- scoreboard bench for the movement elevator controller.
//
// A behavioural elevator model (floor number, countdown timer, signed travel
// direction, per-floor request flags) is stepped on each clock edge with the
// same panel inputs as the DUT; its expected engine/doors values are queued
// and a separate monitor compares them against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_movement;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] interior_panel;
    logic [2:0] exterior_panel;
    logic [1:0] engine;
    logic [2:0] doors;

    movement #(
        .TRAVEL_CYCLES(TRAVEL),
        .DOOR_CYCLES  (DOOR)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .interior_panel(interior_panel),
        .exterior_panel(exterior_panel),
        .engine        (engine),
        .doors         (doors)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] eng;
        logic [2:0] dr;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model state: mode 0 = parked, 1 = travelling, 2 = doors open.
    int m_mode  = 0;
    int m_floor = 0;
    int m_dir   = 0;
    int m_last  = 0;
    int m_timer = 0;
    bit m_req[3];

    task automatic model_step(input bit rst, input logic [2:0] req);
        bit p[3];
        bit np[3];
        bit above, below, further, was_open;
        if (rst) begin
            m_mode = 0; m_floor = 0; m_dir = 0; m_last = 0; m_timer = 0;
            for (int i = 0; i < 3; i++) m_req[i] = 1'b0;
            return;
        end
        p = m_req;
        for (int i = 0; i < 3; i++) np[i] = p[i] | req[i];
        was_open = (m_mode == 2);
        case (m_mode)
            0: begin
                above = 1'b0;
                below = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    if (p[i] && i > m_floor) above = 1'b1;
                    if (p[i] && i < m_floor) below = 1'b1;
                end
                if (p[m_floor]) begin
                    m_mode = 2; m_timer = DOOR;
                end else if (above || below) begin
                    if (above && below) m_dir = (m_last < 0) ? -1 : 1;
                    else                m_dir = above ? 1 : -1;
                    m_last = m_dir; m_mode = 1; m_timer = TRAVEL;
                end
            end
            1: begin
                m_timer--;
                if (m_timer == 0) begin
                    m_floor += m_dir;
                    if (p[m_floor]) begin
                        m_mode = 2; m_timer = DOOR;
                    end else begin
                        further = 1'b0;
                        for (int i = 0; i < 3; i++)
                            if (p[i] && (i - m_floor) * m_dir > 0) further = 1'b1;
                        if (further) m_timer = TRAVEL;
                        else         m_mode = 0;
                    end
                end
            end
            default: begin
                m_timer--;
                if (m_timer == 0) m_mode = 0;
            end
        endcase
        if (was_open || m_mode == 2) np[m_floor] = 1'b0;
        m_req = np;
    endtask

    task automatic push_expected();
        exp_t e;
        e.eng = (m_mode == 1) ? ((m_dir > 0) ? 2'b01 : 2'b10) : 2'b00;
        e.dr  = (m_mode == 2) ? 3'(1 << m_floor) : 3'b000;
        e.cyc = cycle;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic [2:0] ip, input logic [2:0] ep);
        RST            = rst;
        interior_panel = ip;
        exterior_panel = ep;
        @(posedge CLK);
        cycle++;
        model_step(rst, ip | ep);
        push_expected();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 3'b000, 3'b000);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (engine !== e.eng || doors !== e.dr) begin
                    errors++;
                    $display("FAIL outputs @cycle %0d: engine=%b doors=%b, expected engine=%b doors=%b",
                             e.cyc, engine, doors, e.eng, e.dr);
                end
                checks++;
                if (engine === 2'b11) begin
                    errors++;
                    $display("FAIL engine_code @cycle %0d: engine=%b, expected not 11", e.cyc, engine);
                end
            end
        end
    endtask

    initial begin
        RST            = 1'b1;
        interior_panel = 3'b000;
        exterior_panel = 3'b000;
        fork
            monitor();
        join_none

        // Reset, then a long quiet period.
        step(1'b1, 3'b000, 3'b000);
        step(1'b1, 3'b111, 3'b111);
        idle(20);

        // Floor 0 -> 2 car call.
        step(1'b0, 3'b100, 3'b000);
        idle(20);

        // Back at floor 0 via reset; hall call at the current floor.
        step(1'b1, 3'b000, 3'b000);
        step(1'b0, 3'b000, 3'b001);
        idle(8);

        // Two car calls in one cycle: stop at 1, then 2.
        step(1'b0, 3'b110, 3'b000);
        idle(30);

        // From floor 2: car call to 0, then a hall call at 1 while descending.
        step(1'b0, 3'b001, 3'b000);
        idle(3);
        step(1'b0, 3'b000, 3'b010);
        idle(30);

        // Reset mid-move, then a single-hop request.
        step(1'b0, 3'b100, 3'b000);
        idle(3);
        step(1'b1, 3'b000, 3'b000);
        step(1'b0, 3'b010, 3'b000);
        idle(15);

        // Press the current floor while its doors are open.
        step(1'b0, 3'b000, 3'b010);
        idle(1);
        step(1'b0, 3'b010, 3'b000);
        step(1'b0, 3'b000, 3'b010);
        idle(8);

        // Requests both above and below from floor 1.
        step(1'b0, 3'b101, 3'b000);
        idle(40);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            logic       r;
            logic [2:0] ip, ep;
            r = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < 3; b++) begin
                ip[b] = ($urandom_range(0, 15) == 0);
                ep[b] = ($urandom_range(0, 15) == 0);
            end
            step(r, ip, ep);
        end

        step(1'b0, 3'b000, 3'b000);
        // Let the monitor drain the last queued expectations.
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
